// File: rtl/fft_cmac_stage.sv
// fft_cmac_stage: complex multiply-accumulate stage of the FFT accelerator.
//
// Each clk2 cycle, one sample x[mux_sel1] and one twiddle w[mux_sel2] are
// picked from the flattened input buses and multiplied as complex numbers.
// The products are accumulated over an NPTS-step frame. The frame boundaries
// come from mux_sel1: 0 opens a frame and NPTS-1 closes it. At the end of the
// frame one rounded, saturated result goes into a single-entry valid/ready
// output register.
//
// Pipeline: S1 select/register, S2 complex multiply, S3 accumulate/emit.
// The closing sample is accepted at edge E0, and y_valid rises after E2.
//
// Build option: define FFT_CMAC_ROUND_EN for round-half-up at the output.
// Without it, the output is the arithmetic-shift truncation of the sum.
//
// Ports:
//   clk2, rst            clock, asynchronous active-high reset
//   mux_sel1, mux_sel2   sample / twiddle selects from the sequencer
//   out_en               emit enable for the frame being accumulated
//   x_re/x_im_flat       NPTS samples, entry k at [k*DW +: DW]
//   w_re/w_im_flat       NPTS twiddles, entry k at [k*TW +: TW]
//   y_re, y_im, y_valid  result and its valid flag
//   y_ready              consumer accepts the held result
//   ovf                  sticky: an emitted result was saturated
//   drop_err             sticky: a result was discarded under backpressure
module fft_cmac_stage #(
  parameter int DW   = 16,
  parameter int TW   = 16,
  parameter int NPTS = 5,
  parameter int FRAC = 15,
  parameter int AW   = 40
) (
  input  logic                   clk2,
  input  logic                   rst,
  input  logic [2:0]             mux_sel1,
  input  logic [2:0]             mux_sel2,
  input  logic                   out_en,
  input  logic [NPTS*DW-1:0]     x_re_flat,
  input  logic [NPTS*DW-1:0]     x_im_flat,
  input  logic [NPTS*TW-1:0]     w_re_flat,
  input  logic [NPTS*TW-1:0]     w_im_flat,
  output logic signed [DW-1:0]   y_re,
  output logic signed [DW-1:0]   y_im,
  output logic                   y_valid,
  input  logic                   y_ready,
  output logic                   ovf,
  output logic                   drop_err
);

  localparam int LAST = NPTS - 32'sd1;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Clamp to the DW-bit signed range. The MSB of the result flags a clamp.
  function automatic logic [DW:0] sat_dw(input logic signed [AW-1:0] v);
    logic [DW:0] r;
    if (v > SAT_MAX) begin
      r = {1'b1, SAT_MAX[DW-1:0]};
    end else if (v < SAT_MIN) begin
      r = {1'b1, SAT_MIN[DW-1:0]};
    end else begin
      r = {1'b0, v[DW-1:0]};
    end
    return r;
  endfunction

  // Selection. An out-of-range select reads entry 0 so the bus index never
  // leaves the vector; the vld tag then zeroes that product in S2.
  logic                 w_ok1, w_ok2;
  logic [2:0]           w_i1, w_i2;
  logic signed [DW-1:0] w_xr, w_xi;
  logic signed [TW-1:0] w_wr, w_wi;

  assign w_ok1 = int'(mux_sel1) < NPTS;
  assign w_ok2 = int'(mux_sel2) < NPTS;
  assign w_i1  = w_ok1 ? mux_sel1 : 3'd0;
  assign w_i2  = w_ok2 ? mux_sel2 : 3'd0;
  assign w_xr  = x_re_flat[int'(w_i1)*DW +: DW];
  assign w_xi  = x_im_flat[int'(w_i1)*DW +: DW];
  assign w_wr  = w_re_flat[int'(w_i2)*TW +: TW];
  assign w_wi  = w_im_flat[int'(w_i2)*TW +: TW];

  logic signed [DW-1:0] r_xr, r_xi;
  logic signed [TW-1:0] r_wr, r_wi;
  logic                 r_first1, r_last1, r_en1, r_vld1;

  // S1: register the selected operands and the frame tag.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      r_xr     <= {DW{1'b0}};
      r_xi     <= {DW{1'b0}};
      r_wr     <= {TW{1'b0}};
      r_wi     <= {TW{1'b0}};
      r_first1 <= 1'b0;
      r_last1  <= 1'b0;
      r_en1    <= 1'b0;
      r_vld1   <= 1'b0;
    end else begin
      r_xr     <= w_xr;
      r_xi     <= w_xi;
      r_wr     <= w_wr;
      r_wi     <= w_wi;
      r_first1 <= (mux_sel1 == 3'd0);
      r_last1  <= (int'(mux_sel1) == LAST);
      r_en1    <= out_en;
      r_vld1   <= w_ok1 && w_ok2;
    end
  end

  // Operands are sign-extended to AW, so the products and the difference/sum
  // cannot overflow before accumulation.
  logic signed [AW-1:0] w_xr_e, w_xi_e, w_wr_e, w_wi_e, w_pr, w_pi;
  assign w_xr_e = AW'(r_xr);
  assign w_xi_e = AW'(r_xi);
  assign w_wr_e = AW'(r_wr);
  assign w_wi_e = AW'(r_wi);
  assign w_pr   = w_xr_e * w_wr_e - w_xi_e * w_wi_e;
  assign w_pi   = w_xr_e * w_wi_e + w_xi_e * w_wr_e;

  logic signed [AW-1:0] r_pr, r_pi;
  logic                 r_first2, r_last2, r_en2, r_vld2;

  // S2: register the complex product. Invalid selects contribute zero.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      r_pr     <= {AW{1'b0}};
      r_pi     <= {AW{1'b0}};
      r_first2 <= 1'b0;
      r_last2  <= 1'b0;
      r_en2    <= 1'b0;
      r_vld2   <= 1'b0;
    end else begin
      r_pr     <= r_vld1 ? w_pr : {AW{1'b0}};
      r_pi     <= r_vld1 ? w_pi : {AW{1'b0}};
      r_first2 <= r_first1;
      r_last2  <= r_last1;
      r_en2    <= r_en1;
      r_vld2   <= r_vld1;
    end
  end

  logic signed [AW-1:0] r_acc_re, r_acc_im;
  logic signed [AW-1:0] w_sum_re, w_sum_im, w_rnd_re, w_rnd_im, w_shr_re, w_shr_im;
  logic [DW:0]          w_sat_re, w_sat_im;
  logic                 w_emit, w_load;

  // The first step of a frame restarts the sum, so a frame that was cut short
  // never leaks into the next one.
  assign w_sum_re = r_first2 ? r_pr : r_acc_re + r_pr;
  assign w_sum_im = r_first2 ? r_pi : r_acc_im + r_pi;

`ifdef FFT_CMAC_ROUND_EN
  localparam logic signed [AW-1:0] HALF_LSB = {{(AW-1){1'b0}}, 1'b1} << (FRAC-1);
  assign w_rnd_re = w_sum_re + HALF_LSB;
  assign w_rnd_im = w_sum_im + HALF_LSB;
`else
  assign w_rnd_re = w_sum_re;
  assign w_rnd_im = w_sum_im;
`endif

  assign w_shr_re = w_rnd_re >>> FRAC;
  assign w_shr_im = w_rnd_im >>> FRAC;
  assign w_sat_re = sat_dw(w_shr_re);
  assign w_sat_im = sat_dw(w_shr_im);
  assign w_emit   = r_last2 && r_en2 && r_vld2;
  assign w_load   = w_emit && (!y_valid || y_ready);

  // S3: accumulator, single-entry output register and sticky flags.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      r_acc_re <= {AW{1'b0}};
      r_acc_im <= {AW{1'b0}};
      y_re     <= {DW{1'b0}};
      y_im     <= {DW{1'b0}};
      y_valid  <= 1'b0;
      ovf      <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      r_acc_re <= w_sum_re;
      r_acc_im <= w_sum_im;
      if (w_load) begin
        y_re    <= w_sat_re[DW-1:0];
        y_im    <= w_sat_im[DW-1:0];
        y_valid <= 1'b1;
      end else if (y_valid && y_ready) begin
        y_valid <= 1'b0;
      end
      if (w_emit && y_valid && !y_ready) begin
        drop_err <= 1'b1;
      end
      if (w_emit && (w_sat_re[DW] || w_sat_im[DW])) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_cmac_stage.sv
// Self-checking bench for fft_cmac_stage. The reference model works one
// frame at a time. It sums the complex products of the selected entries with
// plain integer arithmetic, rounds and saturates the sum, and schedules the
// result two edges after the closing sample. A held/consumed output slot
// stands in for the single-entry output register.
module tb_fft_cmac_stage;
  localparam int DW = 16, TW = 16, NPTS = 5, FRAC = 15, AW = 40;

  logic clk2 = 1'b0;
  logic rst;
  logic [2:0] mux_sel1, mux_sel2;
  logic out_en, y_ready;
  logic [NPTS*DW-1:0] x_re_flat, x_im_flat;
  logic [NPTS*TW-1:0] w_re_flat, w_im_flat;
  logic signed [DW-1:0] y_re, y_im;
  logic y_valid, ovf, drop_err;

  fft_cmac_stage #(.DW(DW), .TW(TW), .NPTS(NPTS), .FRAC(FRAC), .AW(AW)) dut (
    .clk2(clk2), .rst(rst), .mux_sel1(mux_sel1), .mux_sel2(mux_sel2),
    .out_en(out_en), .x_re_flat(x_re_flat), .x_im_flat(x_im_flat),
    .w_re_flat(w_re_flat), .w_im_flat(w_im_flat), .y_re(y_re), .y_im(y_im),
    .y_valid(y_valid), .y_ready(y_ready), .ovf(ovf), .drop_err(drop_err)
  );

  always #10 clk2 = ~clk2;

  logic signed [15:0] xr[NPTS], xi[NPTS], wr[NPTS], wi[NPTS];
  int n_chk = 0, n_fail = 0;
  int edge_n = 0;
  longint s_re, s_im;
  int q_due[$];
  logic [15:0] q_re[$], q_im[$];
  bit q_cl[$];
  logic mv, movf, mdrop;
  logic [15:0] mre, mim;

  // Scale a frame sum to the output format and clamp it to 16 bits.
  function automatic logic [15:0] to_out(input longint s, output bit clamp);
    longint v;
`ifdef FFT_CMAC_ROUND_EN
    v = (s + 64'sd16384) >>> 15;
`else
    v = s >>> 15;
`endif
    clamp = 1'b0;
    if (v > 64'sd32767) begin
      v = 64'sd32767; clamp = 1'b1;
    end else if (v < -64'sd32768) begin
      v = -64'sd32768; clamp = 1'b1;
    end
    return v[15:0];
  endfunction

  task automatic model_clear();
    mv = 1'b0; movf = 1'b0; mdrop = 1'b0; mre = 16'h0; mim = 16'h0;
    s_re = 0; s_im = 0;
    q_due.delete(); q_re.delete(); q_im.delete(); q_cl.delete();
  endtask

  task automatic set_all(input logic [15:0] vxr, input logic [15:0] vxi,
                         input logic [15:0] vwr, input logic [15:0] vwi);
    for (int k = 0; k < NPTS; k++) begin
      xr[k] = vxr; xi[k] = vxi; wr[k] = vwr; wi[k] = vwi;
    end
  endtask

  // Drive one sequencer step, clock it in and advance the reference model.
  task automatic step(input int a, input int b, input bit en, input bit rdy);
    longint pre, pim;
    bit c1, c2;
    logic [15:0] o_re, o_im;
    mux_sel1 = a[2:0]; mux_sel2 = b[2:0]; out_en = en; y_ready = rdy;
    for (int k = 0; k < NPTS; k++) begin
      x_re_flat[k*DW +: DW] = xr[k]; x_im_flat[k*DW +: DW] = xi[k];
      w_re_flat[k*TW +: TW] = wr[k]; w_im_flat[k*TW +: TW] = wi[k];
    end
    @(posedge clk2);
    edge_n++;
    if (q_due.size() > 0 && q_due[0] == edge_n) begin
      if (!mv || rdy) begin
        mv = 1'b1; mre = q_re[0]; mim = q_im[0];
      end else begin
        mdrop = 1'b1;
      end
      if (q_cl[0]) movf = 1'b1;
      void'(q_due.pop_front()); void'(q_re.pop_front());
      void'(q_im.pop_front()); void'(q_cl.pop_front());
    end else if (mv && rdy) begin
      mv = 1'b0;
    end
    if (a < NPTS && b < NPTS) begin
      pre = longint'(xr[a]) * longint'(wr[b]) - longint'(xi[a]) * longint'(wi[b]);
      pim = longint'(xr[a]) * longint'(wi[b]) + longint'(xi[a]) * longint'(wr[b]);
    end else begin
      pre = 0; pim = 0;
    end
    if (a == 0) begin
      s_re = pre; s_im = pim;
    end else begin
      s_re += pre; s_im += pim;
    end
    if (a == NPTS-1 && en && b < NPTS) begin
      o_re = to_out(s_re, c1); o_im = to_out(s_im, c2);
      q_due.push_back(edge_n + 2); q_re.push_back(o_re);
      q_im.push_back(o_im); q_cl.push_back(c1 | c2);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mux_sel1 = 3'd0; mux_sel2 = 3'd0; out_en = 1'b0; y_ready = 1'b0;
    x_re_flat = '0; x_im_flat = '0; w_re_flat = '0; w_im_flat = '0;
    set_all(16'h0, 16'h0, 16'h0, 16'h0);
    model_clear();
    repeat (2) @(posedge clk2);
    #1;
    n_chk++;
    if ({y_valid, y_re, y_im, ovf, drop_err} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset: got v=%b re=%h im=%h ovf=%b drop=%b, expected all 0",
               y_valid, y_re, y_im, ovf, drop_err);
    end
    #5 rst = 1'b0;
  endtask

  task automatic test_real();
    set_all(16'h1000, 16'h0, 16'h4000, 16'h0);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NPTS; k++) begin
        step(k, k, f > 0, 1'b1);
        n_chk++;
        if ({y_valid, y_re, y_im, ovf, drop_err} !== {mv, mre, mim, movf, mdrop}) begin
          n_fail++;
          $display("FAIL real f%0d k%0d: got v=%b re=%h im=%h ovf=%b drop=%b, expected v=%b re=%h im=%h ovf=%b drop=%b",
                   f, k, y_valid, y_re, y_im, ovf, drop_err, mv, mre, mim, movf, mdrop);
        end
        if (f == 2 && k < 3) begin
          n_chk++;
          if (y_valid !== (k == 1) || (k == 1 && (y_re !== 16'h2800 || y_im !== 16'h0000))) begin
            n_fail++;
            $display("FAIL real_latency k%0d: got v=%b re=%h im=%h, expected v=%b re=2800 im=0000",
                     k, y_valid, y_re, y_im, (k == 1));
          end
        end
      end
    end
  endtask

  task automatic test_imag();
    set_all(16'h0, 16'h1000, 16'h0, 16'h4000);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < NPTS; k++) begin
        step(k, k, 1'b1, 1'b1);
        n_chk++;
        if ({y_valid, y_re, y_im, ovf, drop_err} !== {mv, mre, mim, movf, mdrop}) begin
          n_fail++;
          $display("FAIL imag f%0d k%0d: got v=%b re=%h im=%h ovf=%b drop=%b, expected v=%b re=%h im=%h ovf=%b drop=%b",
                   f, k, y_valid, y_re, y_im, ovf, drop_err, mv, mre, mim, movf, mdrop);
        end
        if (f == 1 && k == 1) begin
          n_chk++;
          if (y_valid !== 1'b1 || y_re !== 16'hD800 || y_im !== 16'h0000) begin
            n_fail++;
            $display("FAIL imag_value: got v=%b re=%h im=%h, expected v=1 re=d800 im=0000",
                     y_valid, y_re, y_im);
          end
        end
      end
    end
  endtask

  task automatic test_sat();
    for (int f = 0; f < 3; f++) begin
      if (f == 0) set_all(16'h7FFF, 16'h0, 16'h7FFF, 16'h0);
      else        set_all(16'h1000, 16'h0, 16'h4000, 16'h0);
      for (int k = 0; k < NPTS; k++) begin
        step(k, k, 1'b1, 1'b1);
        n_chk++;
        if ({y_valid, y_re, y_im, ovf, drop_err} !== {mv, mre, mim, movf, mdrop}) begin
          n_fail++;
          $display("FAIL sat f%0d k%0d: got v=%b re=%h im=%h ovf=%b drop=%b, expected v=%b re=%h im=%h ovf=%b drop=%b",
                   f, k, y_valid, y_re, y_im, ovf, drop_err, mv, mre, mim, movf, mdrop);
        end
        if ((f == 1 && k == 1) || (f == 2 && k == 4)) begin
          n_chk++;
          if (ovf !== 1'b1 || (f == 1 && (y_valid !== 1'b1 || y_re !== 16'h7FFF))) begin
            n_fail++;
            $display("FAIL sat_value f%0d: got v=%b re=%h ovf=%b, expected v=1 re=7fff ovf=1",
                     f, y_valid, y_re, ovf);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] fx[5] = '{16'h1000, 16'h0800, 16'h0400, 16'h1000, 16'h1000};
    bit          fr[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int f = 0; f < 5; f++) begin
      set_all(fx[f], 16'h0, 16'h4000, 16'h0);
      for (int k = 0; k < NPTS; k++) begin
        step(k, k, 1'b1, fr[f]);
        n_chk++;
        if ({y_valid, y_re, y_im, ovf, drop_err} !== {mv, mre, mim, movf, mdrop}) begin
          n_fail++;
          $display("FAIL bp f%0d k%0d: got v=%b re=%h im=%h ovf=%b drop=%b, expected v=%b re=%h im=%h ovf=%b drop=%b",
                   f, k, y_valid, y_re, y_im, ovf, drop_err, mv, mre, mim, movf, mdrop);
        end
        if (f == 2 && k == 4) begin
          n_chk++;
          if (y_valid !== 1'b1 || y_re !== 16'h2800 || drop_err !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b re=%h drop=%b, expected v=1 re=2800 drop=1",
                     y_valid, y_re, drop_err);
          end
        end
        if (f == 3 && k == 1) begin
          n_chk++;
          if (y_valid !== 1'b1 || y_re !== 16'h0A00) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b re=%h, expected v=1 re=0a00", y_valid, y_re);
          end
        end
      end
    end
  endtask

  task automatic test_round();
    logic [15:0] exp_v[3];
`ifdef FFT_CMAC_ROUND_EN
    exp_v = '{16'h0001, 16'h0000, 16'h1000};
`else
    exp_v = '{16'h0000, 16'hFFFF, 16'h1000};
`endif
    for (int f = 0; f < 4; f++) begin
      set_all(16'h0, 16'h0, 16'h4000, 16'h0);
      if (f == 0) xr[0] = 16'h0001;
      if (f == 1) xr[0] = 16'hFFFF;
      if (f >= 2) begin
        set_all(16'h1000, 16'h0, 16'h4000, 16'h0);
        wr[3] = 16'h8000;
      end
      for (int k = 0; k < NPTS; k++) begin
        step(k, k, 1'b1, 1'b1);
        n_chk++;
        if ({y_valid, y_re, y_im, ovf, drop_err} !== {mv, mre, mim, movf, mdrop}) begin
          n_fail++;
          $display("FAIL round f%0d k%0d: got v=%b re=%h im=%h ovf=%b drop=%b, expected v=%b re=%h im=%h ovf=%b drop=%b",
                   f, k, y_valid, y_re, y_im, ovf, drop_err, mv, mre, mim, movf, mdrop);
        end
        if (f > 0 && k == 1) begin
          n_chk++;
          if (y_valid !== 1'b1 || y_re !== exp_v[f-1]) begin
            n_fail++;
            $display("FAIL round_value f%0d: got v=%b re=%h, expected v=1 re=%h",
                     f - 1, y_valid, y_re, exp_v[f-1]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < NPTS; k++) begin
        xr[k] = 16'($urandom); xi[k] = 16'($urandom);
        wr[k] = 16'($urandom); wi[k] = 16'($urandom);
      end
      if (f % 4 == 3) begin
        step(7, 7, 1'b1, 1'($urandom));
        n_chk++;
        if ({y_valid, y_re, y_im, ovf, drop_err} !== {mv, mre, mim, movf, mdrop}) begin
          n_fail++;
          $display("FAIL b2b idle f%0d: got v=%b re=%h im=%h ovf=%b drop=%b, expected v=%b re=%h im=%h ovf=%b drop=%b",
                   f, y_valid, y_re, y_im, ovf, drop_err, mv, mre, mim, movf, mdrop);
        end
      end
      for (int k = 0; k < NPTS; k++) begin
        step(k, int'($urandom_range(0, 6)), 1'b1, 1'($urandom));
        n_chk++;
        if ({y_valid, y_re, y_im, ovf, drop_err} !== {mv, mre, mim, movf, mdrop}) begin
          n_fail++;
          $display("FAIL b2b f%0d k%0d: got v=%b re=%h im=%h ovf=%b drop=%b, expected v=%b re=%h im=%h ovf=%b drop=%b",
                   f, k, y_valid, y_re, y_im, ovf, drop_err, mv, mre, mim, movf, mdrop);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_all(16'h1000, 16'h0, 16'h4000, 16'h0);
    for (int k = 0; k < 3; k++) step(k, k, 1'b1, 1'b0);
    rst = 1'b1;
    model_clear();
    #1;
    n_chk++;
    if ({y_valid, y_re, y_im, ovf, drop_err} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b re=%h im=%h ovf=%b drop=%b, expected all 0",
               y_valid, y_re, y_im, ovf, drop_err);
    end
    @(posedge clk2);
    #5 rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NPTS; k++) begin
        step(k, k, f > 0, 1'b1);
        n_chk++;
        if ({y_valid, y_re, y_im, ovf, drop_err} !== {mv, mre, mim, movf, mdrop}) begin
          n_fail++;
          $display("FAIL reset_mid f%0d k%0d: got v=%b re=%h im=%h ovf=%b drop=%b, expected v=%b re=%h im=%h ovf=%b drop=%b",
                   f, k, y_valid, y_re, y_im, ovf, drop_err, mv, mre, mim, movf, mdrop);
        end
        if (f < 2 || k == 1) begin
          n_chk++;
          if (y_valid !== (f == 2) || (f == 2 && y_re !== 16'h2800)) begin
            n_fail++;
            $display("FAIL reset_mid_first f%0d k%0d: got v=%b re=%h, expected v=%b re=2800",
                     f, k, y_valid, y_re, (f == 2));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_real();
    test_imag();
    test_sat();
    test_backpressure();
    test_round();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
